// File: rtl/act_pkg.sv
// Shared types and default dimensions for the activation row dispatcher
// and the sblk row it feeds.
package act_pkg;

   localparam int N_ROW_DEF   = 4;
   localparam int WID_ACT_DEF = 16;

   // One packed activation pair as carried on a row bus.
   typedef logic [2*WID_ACT_DEF-1:0] act_pair_t;

   // Row-select width, never narrower than one bit.
   function automatic int row_sel_width(input int n_row);
      return (n_row > 1) ? $clog2(n_row) : 1;
   endfunction

endpackage

// File: rtl/act_fifo.sv
// Per-row synchronous FIFO with a registered read port. The read register is
// the row's output data register, so it holds its value between pops.
module act_fifo
   import act_pkg::*;
#(
   parameter int WIDTH = 2*WID_ACT_DEF,
   parameter int DEPTH = 4
) (
   input  logic             clk_l,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   // A full FIFO refuses pushes even when it is popped in the same cycle;
   // an empty FIFO cannot pop the word being pushed this cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointer and read-register update; reset discards all buffered words.
   always_ff @(posedge clk_l) begin
      // NOTE: state is written with <= so every register samples pre-edge values.
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         dout   <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop) begin
            dout   <= mem[rd_ptr[AW-1:0]];
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   // Storage array write.
   always_ff @(posedge clk_l) begin
      // NOTE: the array has no reset; the pointers alone define which entries are valid.
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/act_row_dispatch.sv
// Activation row dispatcher: steers loader words to one row or all rows
// through per-row FIFOs and keeps per-row delivered-word counters.
module act_row_dispatch
   import act_pkg::*;
#(
   parameter int N_ROW      = N_ROW_DEF,
   parameter int WID_ACT    = WID_ACT_DEF,
   parameter int FIFO_DEPTH = 4,
   parameter int WID_ROW    = row_sel_width(N_ROW),
   parameter int WID_CNT    = 16
) (
   input  logic                       clk_l,
   input  logic                       rst,
   input  logic [2*WID_ACT-1:0]       s_data,
   input  logic [WID_ROW-1:0]         s_row,
   input  logic                       s_bcast,
   input  logic                       s_vld,
   output logic                       s_rdy,
   output logic [2*WID_ACT*N_ROW-1:0] act_data_in,
   output logic [N_ROW-1:0]           act_data_in_vld,
   input  logic [N_ROW-1:0]           act_data_in_req,
   input  logic                       cnt_clr,
   output logic [WID_CNT*N_ROW-1:0]   row_cnt,
   output logic                       err_row
);

   localparam int WID_WORD = 2*WID_ACT;

   logic [N_ROW-1:0]   row_hit;
   logic               unicast_ok;
   logic               xfer;
   logic [N_ROW-1:0]   wen;
   logic [N_ROW-1:0]   full;
   logic [N_ROW-1:0]   empty;
   logic [N_ROW-1:0]   pop;
   logic [N_ROW-1:0]   vld_q;
   logic [WID_CNT-1:0] cnt_q [N_ROW];
   logic               err_q;

   // One-hot decode of the unicast destination; all-zero when s_row is out of range.
   always_comb begin
      // NOTE: default first so every path assigns every bit and no latch is inferred.
      row_hit = '0;
      for (int r = 0; r < N_ROW; r++) begin
         row_hit[r] = (s_row == WID_ROW'(r));
      end
   end

   assign unicast_ok = |row_hit;
   // Broadcast needs room in every row; an out-of-range unicast is accepted and dropped.
   assign s_rdy = s_bcast ? ~|full : (~unicast_ok | ~|(row_hit & full));
   assign xfer  = s_vld & s_rdy & ~rst;
   assign wen   = xfer ? (s_bcast ? {N_ROW{1'b1}} : row_hit) : '0;
   assign pop   = ~empty & act_data_in_req;

   generate
      for (genvar g = 0; g < N_ROW; g++) begin : g_row
         act_fifo #(
            .WIDTH (WID_WORD),
            .DEPTH (FIFO_DEPTH)
         ) u_fifo (
            .clk_l (clk_l),
            .rst   (rst),
            .push  (wen[g]),
            .pop   (pop[g]),
            .din   (s_data),
            .dout  (act_data_in[g*WID_WORD +: WID_WORD]),
            .full  (full[g]),
            .empty (empty[g])
         );
         assign row_cnt[g*WID_CNT +: WID_CNT] = cnt_q[g];
      end
   endgenerate

   assign act_data_in_vld = vld_q;
   assign err_row         = err_q;

   // Per-row valid pulse, registered alongside the FIFO read register.
   always_ff @(posedge clk_l) begin
      if (rst) vld_q <= '0;
      else     vld_q <= pop;
   end

   // Saturating delivered-word counters; clear wins over a same-cycle delivery.
   always_ff @(posedge clk_l) begin
      for (int r = 0; r < N_ROW; r++) begin
         if (rst || cnt_clr)                 cnt_q[r] <= '0;
         else if (pop[r] && (cnt_q[r] != '1)) cnt_q[r] <= cnt_q[r] + WID_CNT'(1);
      end
   end

   // Sticky flag for an accepted unicast word with no matching row.
   always_ff @(posedge clk_l) begin
      if (rst)                                err_q <= 1'b0;
      else if (xfer && !s_bcast && !unicast_ok) err_q <= 1'b1;
   end

endmodule

// File: tb/tb_act_row_dispatch.sv
// Directed bench for act_row_dispatch: a 4-row instance for the main flows
// and a 3-row, 4-bit-counter instance for the bad-row and saturation cases.
module tb_act_row_dispatch;
   import act_pkg::*;

   localparam int NR  = 4;
   localparam int WW  = 32;
   localparam int WC  = 16;
   localparam int NR3 = 3;
   localparam int WC3 = 4;

   logic clk_l = 1'b0;
   logic rst   = 1'b1;
   always #5 clk_l = ~clk_l;

   // 4-row instance
   act_pair_t         s_data = '0;
   logic [1:0]        s_row = '0;
   logic              s_bcast = 1'b0;
   logic              s_vld = 1'b0;
   logic              s_rdy;
   logic [WW*NR-1:0]  act_data_in;
   logic [NR-1:0]     act_data_in_vld;
   logic [NR-1:0]     act_data_in_req = '0;
   logic              cnt_clr = 1'b0;
   logic [WC*NR-1:0]  row_cnt;
   logic              err_row;

   // 3-row instance
   act_pair_t         b_s_data = '0;
   logic [1:0]        b_s_row = '0;
   logic              b_s_bcast = 1'b0;
   logic              b_s_vld = 1'b0;
   logic              b_s_rdy;
   logic [WW*NR3-1:0] b_act_data_in;
   logic [NR3-1:0]    b_act_data_in_vld;
   logic [NR3-1:0]    b_act_data_in_req = '0;
   logic              b_cnt_clr = 1'b0;
   logic [WC3*NR3-1:0] b_row_cnt;
   logic              b_err_row;

   int checks = 0;
   int errors = 0;

   act_row_dispatch #(.N_ROW(NR), .WID_ACT(16), .FIFO_DEPTH(4), .WID_CNT(WC)) u_dut (
      .clk_l(clk_l), .rst(rst), .s_data(s_data), .s_row(s_row), .s_bcast(s_bcast),
      .s_vld(s_vld), .s_rdy(s_rdy), .act_data_in(act_data_in),
      .act_data_in_vld(act_data_in_vld), .act_data_in_req(act_data_in_req),
      .cnt_clr(cnt_clr), .row_cnt(row_cnt), .err_row(err_row)
   );

   act_row_dispatch #(.N_ROW(NR3), .WID_ACT(16), .FIFO_DEPTH(4), .WID_CNT(WC3)) u_dut3 (
      .clk_l(clk_l), .rst(rst), .s_data(b_s_data), .s_row(b_s_row), .s_bcast(b_s_bcast),
      .s_vld(b_s_vld), .s_rdy(b_s_rdy), .act_data_in(b_act_data_in),
      .act_data_in_vld(b_act_data_in_vld), .act_data_in_req(b_act_data_in_req),
      .cnt_clr(b_cnt_clr), .row_cnt(b_row_cnt), .err_row(b_err_row)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; outputs are then stable for sampling.
   task automatic tick;
      @(posedge clk_l);
      #1;
   endtask

   function automatic act_pair_t dat(input int r);
      return act_data_in[r*WW +: WW];
   endfunction

   function automatic logic [WC-1:0] cnt(input int r);
      return row_cnt[r*WC +: WC];
   endfunction

   logic [NR-1:0]  seen;
   logic [NR3-1:0] b_seen;

   initial begin
      // ---------------- reset state ----------------
      rst = 1'b1;
      tick; tick; tick;
      check("rst_vld",     64'(act_data_in_vld), 64'h0);
      check("rst_data",    64'(act_data_in[63:0]), 64'h0);
      check("rst_cnt",     row_cnt, 64'h0);
      check("rst_err",     64'(err_row), 64'h0);
      check("rst_err_b",   64'(b_err_row), 64'h0);
      rst = 1'b0;
      tick;

      // ---------------- T1 unicast ----------------
      act_data_in_req = 4'b1111;
      s_data = 32'hAAAA_0001; s_row = 2'd2; s_bcast = 1'b0; s_vld = 1'b1;
      check("t1_rdy", 64'(s_rdy), 64'h1);
      tick;                                   // transfer edge
      s_vld = 1'b0;
      check("t1_no_bypass", 64'(act_data_in_vld), 64'h0);
      tick;                                   // pop edge
      check("t1_vld",  64'(act_data_in_vld), 64'h4);
      check("t1_data", 64'(dat(2)), 64'hAAAA_0001);
      check("t1_cnt",  64'(cnt(2)), 64'h1);
      tick;
      check("t1_pulse_end", 64'(act_data_in_vld), 64'h0);
      check("t1_data_hold", 64'(dat(2)), 64'hAAAA_0001);

      // ---------------- T2 backpressure ----------------
      act_data_in_req = 4'b1101;
      s_row = 2'd1;
      for (int i = 0; i < 4; i++) begin
         s_data = 32'h1111_0000 + 32'(i); s_vld = 1'b1;
         check("t2_rdy_fill", 64'(s_rdy), 64'h1);
         tick;
      end
      s_data = 32'h1111_0004;
      check("t2_rdy_full", 64'(s_rdy), 64'h0);
      tick;                                   // blocked edge
      check("t2_no_pop", 64'(act_data_in_vld), 64'h0);
      act_data_in_req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick;
         check("t2_vld",  64'(act_data_in_vld), 64'h2);
         check("t2_data", 64'(dat(1)), 64'h1111_0000 + 64'(i));
         if (i == 1) s_vld = 1'b0;            // 5th word entered on this edge
      end
      tick;
      check("t2_no_dup", 64'(act_data_in_vld), 64'h0);
      check("t2_cnt",    64'(cnt(1)), 64'd5);

      // ---------------- T3 broadcast ----------------
      act_data_in_req = 4'b0111;
      s_row = 2'd3;
      for (int i = 0; i < 4; i++) begin
         s_data = 32'h3333_0000 + 32'(i); s_vld = 1'b1;
         tick;
      end
      s_data = 32'hBBBB_BBBB; s_bcast = 1'b1;
      check("t3_rdy_blocked", 64'(s_rdy), 64'h0);
      tick;
      check("t3_none_written", 64'(act_data_in_vld), 64'h0);
      act_data_in_req = 4'b1111;
      tick;                                   // one entry drained from row 3
      check("t3_drain_vld",  64'(act_data_in_vld), 64'h8);
      check("t3_drain_data", 64'(dat(3)), 64'h3333_0000);
      act_data_in_req = 4'b0111;
      check("t3_rdy_open", 64'(s_rdy), 64'h1);
      tick;                                   // broadcast written to all rows
      s_vld = 1'b0; s_bcast = 1'b0;
      check("t3_latency", 64'(act_data_in_vld), 64'h0);
      tick;
      check("t3_bc_vld", 64'(act_data_in_vld), 64'h7);
      check("t3_bc_d0",  64'(dat(0)), 64'hBBBB_BBBB);
      check("t3_bc_d1",  64'(dat(1)), 64'hBBBB_BBBB);
      check("t3_bc_d2",  64'(dat(2)), 64'hBBBB_BBBB);
      check("t3_cnt0",   64'(cnt(0)), 64'd1);
      check("t3_cnt1",   64'(cnt(1)), 64'd6);
      check("t3_cnt2",   64'(cnt(2)), 64'd2);
      act_data_in_req = 4'b1111;
      for (int i = 1; i < 4; i++) begin
         tick;
         check("t3_row3_data", 64'(dat(3)), 64'h3333_0000 + 64'(i));
      end
      tick;
      check("t3_row3_vld", 64'(act_data_in_vld), 64'h8);
      check("t3_row3_bc",  64'(dat(3)), 64'hBBBB_BBBB);
      check("t3_cnt3",     64'(cnt(3)), 64'd5);
      check("t3_no_err",   64'(err_row), 64'h0);

      // ---------------- T4 bad row (3-row instance) ----------------
      b_act_data_in_req = 3'b111;
      b_s_data = 32'hDEAD_0003; b_s_row = 2'd3; b_s_bcast = 1'b0; b_s_vld = 1'b1;
      check("t4_rdy", 64'(b_s_rdy), 64'h1);
      tick;
      b_s_vld = 1'b0;
      check("t4_err", 64'(b_err_row), 64'h1);
      b_seen = '0;
      for (int i = 0; i < 3; i++) begin
         tick;
         b_seen |= b_act_data_in_vld;
      end
      check("t4_no_vld", 64'(b_seen), 64'h0);
      b_cnt_clr = 1'b1;
      tick;
      b_cnt_clr = 1'b0;
      check("t4_err_sticky", 64'(b_err_row), 64'h1);

      // ---------------- T6a saturation (3-row instance, 4-bit counters) ----------------
      b_s_row = 2'd0;
      for (int i = 0; i < 15; i++) begin
         b_s_data = 32'h0600_0000 + 32'(i); b_s_vld = 1'b1;
         tick;
      end
      b_s_vld = 1'b0;
      tick; tick;
      check("t6_cnt_max", 64'(b_row_cnt[WC3-1:0]), 64'hF);
      b_s_data = 32'h0600_00FF; b_s_vld = 1'b1;
      tick;
      b_s_vld = 1'b0;
      tick;
      check("t6_sat_vld", 64'(b_act_data_in_vld), 64'h1);
      check("t6_sat_cnt", 64'(b_row_cnt[WC3-1:0]), 64'hF);

      // ---------------- T5 reset mid-stream ----------------
      act_data_in_req = 4'b0000;
      s_bcast = 1'b1;
      for (int i = 0; i < 3; i++) begin
         s_data = 32'h5555_0000 + 32'(i); s_vld = 1'b1;
         tick;
      end
      s_data = 32'h5555_0009;                 // offered during reset, must be refused
      rst = 1'b1;
      tick;
      rst = 1'b0; s_vld = 1'b0; s_bcast = 1'b0;
      check("t5_vld",   64'(act_data_in_vld), 64'h0);
      check("t5_cnt",   row_cnt, 64'h0);
      check("t5_data",  64'(dat(3)), 64'h0);
      check("t5_err_b", 64'(b_err_row), 64'h0);
      act_data_in_req = 4'b1111;
      seen = '0;
      for (int i = 0; i < 5; i++) begin
         tick;
         seen |= act_data_in_vld;
      end
      check("t5_no_stale", 64'(seen), 64'h0);

      // ---------------- T6b clear vs delivery ----------------
      s_row = 2'd1; s_data = 32'h6666_0001; s_vld = 1'b1;
      tick;
      s_vld = 1'b0;
      tick;
      check("t6_pre_cnt1", 64'(cnt(1)), 64'd1);
      s_row = 2'd0; s_data = 32'h6666_0000; s_vld = 1'b1;
      tick;
      s_vld = 1'b0; cnt_clr = 1'b1;
      tick;                                   // delivery and clear on the same edge
      cnt_clr = 1'b0;
      check("t6_clr_vld",  64'(act_data_in_vld), 64'h1);
      check("t6_clr_data", 64'(dat(0)), 64'h6666_0000);
      check("t6_clr_cnt",  row_cnt, 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
